hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_pkg.sv | 25 ++
 rtl/hazard_stall_ctrl_if.sv | 47 ++++
 rtl/hazard_stall_ctrl_match.sv | 42 ++++
 rtl/hazard_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
// Imported by the interface, the comparator and the top.
package hazard_stall_ctrl_pkg;

    localparam int RA_W    = 4;
    localparam int STALL_W = 2;
    localparam int CNT_W   = 16;

    localparam logic [RA_W-1:0] ZERO_REG = '0;
    localparam logic [1:0]      RW_NONE  = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_e;

    typedef struct packed {
        logic lu;
        logic ba;
        logic bl;
        logic bm;
    } hz_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID/EX/MEM pipeline and the stall controller.
// master drives hazard/memory status, slave returns the stall controls.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_branch;
    logic             br_taken;
    logic [RA_W-1:0]  ex_rd;
    logic [1:0]       ex_regwrite;
    logic             ex_memread;
    logic [RA_W-1:0]  mem_rd;
    logic             mem_memread;
    logic             dmem_req;
    logic             dmem_ready;
    logic             Delay;
    logic             pc_write;
    logic             ifid_write;
    logic             if_flush;
    logic             pipe_freeze;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_is_branch, br_taken,
        output ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_memread,
        output dmem_req, dmem_ready,
        input  Delay, pc_write, ifid_write, if_flush,
        input  pipe_freeze, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_is_branch, br_taken,
        input  ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_memread,
        input  dmem_req, dmem_ready,
        output Delay, pc_write, ifid_write, if_flush,
        output pipe_freeze, mem_err, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_ctrl_match.sv
// Combinational comparator of ID sources against EX/MEM destinations.
// r0 never produces a hit.
module hazard_match
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [RA_W-1:0] id_rs_i,
    input  logic [RA_W-1:0] id_rt_i,
    input  logic            id_uses_rs_i,
    input  logic            id_uses_rt_i,
    input  logic            id_is_branch_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic [1:0]      ex_regwrite_i,
    input  logic            ex_memread_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            mem_memread_i,
    output hz_t             hz_o
);

    logic ex_hit;
    logic mem_hit;
    logic ex_wr;

    assign ex_hit = (ex_rd_i != ZERO_REG) &&
                    ((id_uses_rs_i && id_rs_i == ex_rd_i) ||
                     (id_uses_rt_i && id_rt_i == ex_rd_i));

    assign mem_hit = (mem_rd_i != ZERO_REG) &&
                     ((id_uses_rs_i && id_rs_i == mem_rd_i) ||
                      (id_uses_rt_i && id_rt_i == mem_rd_i));

    assign ex_wr = (ex_regwrite_i != RW_NONE);

    // Classify the hazard terms
    always_comb begin
        hz_o    = '0;
        hz_o.lu = ex_memread_i && ex_wr && ex_hit;
        hz_o.ba = id_is_branch_i && !ex_memread_i && ex_wr && ex_hit;
        hz_o.bl = id_is_branch_i && ex_memread_i && ex_hit;
        hz_o.bm = id_is_branch_i && mem_memread_i && mem_hit;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall controller: bubbles, PC/IF-ID enables, flush, freeze.
// Multi-cycle stalls are held in a small FSM with a down-counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    hazard_stall_ctrl_if.slave bus
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               merr_q, merr_d;
    logic [CNT_W-1:0]   stat_q, stat_d;

    hz_t  hz;
    logic frz_req;
    logic dly, pcw, flush, frz;

    hazard_match u_match (
        .id_rs_i        (bus.id_rs),
        .id_rt_i        (bus.id_rt),
        .id_uses_rs_i   (bus.id_uses_rs),
        .id_uses_rt_i   (bus.id_uses_rt),
        .id_is_branch_i (bus.id_is_branch),
        .ex_rd_i        (bus.ex_rd),
        .ex_regwrite_i  (bus.ex_regwrite),
        .ex_memread_i   (bus.ex_memread),
        .mem_rd_i       (bus.mem_rd),
        .mem_memread_i  (bus.mem_memread),
        .hz_o           (hz)
    );

    assign frz_req = bus.dmem_req && !bus.dmem_ready;

    // Next state, counters and stall controls
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        merr_d  = merr_q;
        stat_d  = stat_q;
        dly     = 1'b0;
        pcw     = 1'b0;
        flush   = 1'b0;
        frz     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frz_req) begin
                    frz     = 1'b1;
                    state_d = FREEZE;
                    ret_d   = IDLE;
                    tmo_d   = TMO_W'(1);
                end else if (hz.bl) begin
                    dly     = 1'b1;
                    cnt_d   = STALL_W'(1);
                    state_d = STALL;
                end else if (hz.lu || hz.ba || hz.bm) begin
                    dly = 1'b1;
                end else begin
                    pcw   = 1'b1;
                    flush = bus.id_is_branch && bus.br_taken;
                end
            end
            STALL: begin
                if (frz_req) begin
                    frz     = 1'b1;
                    state_d = FREEZE;
                    ret_d   = STALL;
                    tmo_d   = TMO_W'(1);
                end else begin
                    dly   = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = IDLE;
                end
            end
            FREEZE: begin
                frz = 1'b1;
                if (tmo_q != TMO_W'(MEM_TIMEOUT)) tmo_d = tmo_q + 1'b1;
                if (bus.dmem_ready) state_d = ret_q;
            end
            default: state_d = IDLE;
        endcase
        if (frz && tmo_d == TMO_W'(MEM_TIMEOUT)) merr_d = 1'b1;
        if (dly && !frz && stat_q != '1) stat_d = stat_q + 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            merr_q  <= 1'b0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            merr_q  <= merr_d;
            stat_q  <= stat_d;
        end
    end

    assign bus.Delay        = reset | dly;
    assign bus.pc_write     = !reset & pcw;
    assign bus.ifid_write   = !reset & pcw;
    assign bus.if_flush     = reset | flush;
    assign bus.pipe_freeze  = !reset & frz;
    assign bus.mem_err      = merr_q;
    assign bus.stall_cycles = stat_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios, then
// random traffic, all against a bubble/freeze-level reference model.
module tb_hazard_stall_ctrl;

    localparam int TMO = 8;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    int   m_bub;
    bit   m_frz;
    int   m_run;
    bit   m_err;
    int   m_stat;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_hit(input int x);
        return x != 0 &&
               ((bus.id_uses_rs && int'(bus.id_rs) == x) ||
                (bus.id_uses_rt && int'(bus.id_rt) == x));
    endfunction

    task automatic clr();
        bus.id_rs = 0; bus.id_rt = 0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.id_is_branch = 0; bus.br_taken = 0;
        bus.ex_rd = 0; bus.ex_regwrite = 0; bus.ex_memread = 0;
        bus.mem_rd = 0; bus.mem_memread = 0;
        bus.dmem_req = 0; bus.dmem_ready = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model
    task automatic step();
        bit e_dly, e_pcw, e_fl, e_frz;
        bit lu, ba, bl, bm, exw, fz;
        #4;
        e_dly = 0; e_pcw = 0; e_fl = 0; e_frz = 0;
        exw = bus.ex_regwrite != 0;
        lu = bus.ex_memread && exw && src_hit(int'(bus.ex_rd));
        ba = bus.id_is_branch && !bus.ex_memread && exw &&
             src_hit(int'(bus.ex_rd));
        bl = bus.id_is_branch && bus.ex_memread &&
             src_hit(int'(bus.ex_rd));
        bm = bus.id_is_branch && bus.mem_memread &&
             src_hit(int'(bus.mem_rd));
        fz = m_frz || (bus.dmem_req && !bus.dmem_ready);
        if (reset) begin
            e_dly = 1; e_fl = 1;
        end else if (fz) begin
            e_frz = 1;
        end else if (m_bub > 0) begin
            e_dly = 1;
        end else if (bl || lu || ba || bm) begin
            e_dly = 1;
        end else begin
            e_pcw = 1;
            e_fl = bus.id_is_branch && bus.br_taken;
        end
        chk("Delay", bus.Delay, e_dly);
        chk("pc_write", bus.pc_write, e_pcw);
        chk("ifid_write", bus.ifid_write, e_pcw);
        chk("if_flush", bus.if_flush, e_fl);
        chk("pipe_freeze", bus.pipe_freeze, e_frz);
        chk("mem_err", bus.mem_err, m_err);
        chk("stall_cycles", bus.stall_cycles, m_stat);
        if (reset) begin
            m_bub = 0; m_frz = 0; m_run = 0; m_err = 0; m_stat = 0;
        end else if (fz) begin
            m_run = m_frz ? (m_run < TMO ? m_run + 1 : TMO) : 1;
            if (m_run >= TMO) m_err = 1;
            m_frz = m_frz ? !bus.dmem_ready : 1'b1;
        end else begin
            if (m_bub > 0) m_bub--;
            else if (bl) m_bub = 1;
            if (e_dly && m_stat < 65535) m_stat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic br_after_load(input int r);
        clr();
        bus.id_is_branch = 1; bus.br_taken = 1;
        bus.id_rt = 4'(r); bus.id_uses_rt = 1;
        bus.ex_memread = 1; bus.ex_regwrite = 2'b01; bus.ex_rd = 4'(r);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        m_bub = 0; m_frz = 0; m_run = 0; m_err = 0; m_stat = 0;
        clr();
        reset = 1;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 0;
        step();

        // load-use
        bus.ex_memread = 1; bus.ex_regwrite = 2'b01; bus.ex_rd = 3;
        bus.id_rs = 3; bus.id_uses_rs = 1;
        step();
        bus.ex_memread = 0; bus.ex_regwrite = 0; bus.ex_rd = 0;
        bus.mem_memread = 1; bus.mem_rd = 3;
        step();
        chk("lu_stat", bus.stall_cycles, 1);
        clr();

        // branch after load: two bubbles, then taken flush
        br_after_load(5);
        step();
        bus.ex_memread = 0; bus.ex_regwrite = 0; bus.ex_rd = 0;
        bus.mem_memread = 1; bus.mem_rd = 5;
        step();
        bus.mem_memread = 0; bus.mem_rd = 0;
        step();
        clr();
        step();
        chk("bl_stat", bus.stall_cycles, 3);

        // r0 and no-write never stall
        bus.ex_memread = 1; bus.ex_regwrite = 2'b01; bus.ex_rd = 0;
        bus.id_rs = 0; bus.id_uses_rs = 1;
        step();
        bus.ex_regwrite = 2'b00; bus.ex_rd = 6; bus.id_rs = 6;
        step();
        clr();

        // freeze from IDLE
        bus.dmem_req = 1;
        repeat (4) step();
        bus.dmem_ready = 1;
        step();
        clr();
        step();

        // freeze landing in mid-STALL
        br_after_load(7);
        step();
        bus.ex_memread = 0; bus.ex_regwrite = 0;
        bus.dmem_req = 1;
        repeat (3) step();
        bus.dmem_ready = 1;
        step();
        bus.dmem_req = 0; bus.dmem_ready = 0;
        step();
        clr();
        step();

        // timeout, sticky until reset
        bus.dmem_req = 1;
        repeat (TMO + 2) step();
        chk("tmo_err", bus.mem_err, 1);
        bus.dmem_ready = 1;
        step();
        clr();
        step();
        step();

        // reset in the middle of a 2-bubble stall
        br_after_load(2);
        step();
        reset = 1;
        step();
        reset = 0;
        clr();
        step();
        chk("rst_stat", bus.stall_cycles, 0);
        chk("rst_err", bus.mem_err, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(63) == 0);
            bus.id_rs = 4'($urandom_range(3));
            bus.id_rt = 4'($urandom_range(3));
            bus.id_uses_rs = 1'($urandom);
            bus.id_uses_rt = 1'($urandom);
            bus.id_is_branch = 1'($urandom);
            bus.br_taken = 1'($urandom);
            bus.ex_rd = 4'($urandom_range(3));
            bus.ex_regwrite = 2'($urandom);
            bus.ex_memread = 1'($urandom);
            bus.mem_rd = 4'($urandom_range(3));
            bus.mem_memread = 1'($urandom);
            bus.dmem_req = ($urandom_range(5) == 0) || m_frz;
            bus.dmem_ready = ($urandom_range(2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
